// File: rtl/ysyx_24110006_pc_gen_if.sv
// Fetch-request bundle between the PC generator and the IFU, plus redirect inputs.
// Latency: none (wires only).
// Backpressure: o_valid/i_ready handshake; the master holds o_pc/o_epoch until accepted.
interface ysyx_24110006_pc_gen_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] o_pc;
   logic            o_epoch;
   logic            o_valid;
   logic            i_ready;
   logic            i_retire;
   logic            i_redirect;
   logic [XLEN-1:0] i_redirect_pc;
   logic            i_trap;
   logic [XLEN-1:0] i_trap_pc;
   logic            o_fault;
   logic [XLEN-1:0] o_fault_pc;

   // PC generator side
   modport master (
      output o_pc, o_epoch, o_valid, o_fault, o_fault_pc,
      input  i_ready, i_retire, i_redirect, i_redirect_pc, i_trap, i_trap_pc
   );

   // IFU / redirect-source side
   modport slave (
      input  o_pc, o_epoch, o_valid, o_fault, o_fault_pc,
      output i_ready, i_retire, i_redirect, i_redirect_pc, i_trap, i_trap_pc
   );
endinterface

// File: rtl/ysyx_24110006_pc_gen.sv
// Program-counter generator: issues fetch PCs, limits in-flight fetches by credits, applies trap/branch redirects with epoch tagging.
// Latency: first request two cycles after reset release, then one per cycle; a redirect shows on o_pc the next cycle.
// Backpressure: request held while !i_ready; issue pauses once MAX_OUTSTANDING fetches are unretired.
// Optional macro PCGEN_MISALIGN_CHK_EN: misaligned redirect targets park the generator in FAULT until a trap.
module ysyx_24110006_pc_gen #(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR    = XLEN'(32'h3000_0000),
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   ysyx_24110006_pc_gen_if.master req
);
   typedef enum logic [2:0] {S_RESET, S_BOOT, S_RUN, S_FULL, S_FAULT} state_t;

   localparam logic [3:0] CREDIT_MAX = 4'(MAX_OUTSTANDING);

   state_t          state, state_nxt, credit_state;
   logic [XLEN-1:0] pc, pc_nxt, target;
   logic            epoch, epoch_nxt;
   logic [3:0]      credits, credits_nxt;
   logic            fire, retire, load;
`ifdef PCGEN_MISALIGN_CHK_EN
   logic            fault, fault_nxt;
   logic [XLEN-1:0] fault_pc, fault_pc_nxt;
`endif

   // Next-state: credit accounting, sequential +4 step, and redirect/trap loading (trap wins)
   always_comb begin
      fire         = (state == S_RUN) && req.i_ready;
      // A retire with nothing outstanding is dropped so the counter cannot underflow
      retire       = req.i_retire && (credits != 4'd0);
      credits_nxt  = credits + {3'd0, fire} - {3'd0, retire};
      credit_state = (credits_nxt >= CREDIT_MAX) ? S_FULL : S_RUN;
      target       = req.i_trap ? req.i_trap_pc : req.i_redirect_pc;
      state_nxt    = state;
      pc_nxt       = pc;
      epoch_nxt    = epoch;
      load         = 1'b0;
`ifdef PCGEN_MISALIGN_CHK_EN
      fault_nxt    = fault;
      fault_pc_nxt = fault_pc;
`endif
      case (state)
         S_RESET: state_nxt = S_BOOT;
         S_BOOT:  state_nxt = S_RUN;
         S_RUN, S_FULL: begin
            state_nxt = credit_state;
            if (fire) pc_nxt = pc + XLEN'(4);
            load = req.i_trap || req.i_redirect;
         end
         // Only a trap (mtvec) can pull the generator out of a fault
         S_FAULT: load = req.i_trap;
         default: state_nxt = S_RESET;
      endcase
      // A redirect overrides the +4 step; a same-cycle fire keeps its credit and the old epoch
      if (load) begin
         epoch_nxt = ~epoch;
`ifdef PCGEN_MISALIGN_CHK_EN
         if (target[1:0] != 2'b00) begin
            state_nxt    = S_FAULT;
            fault_nxt    = 1'b1;
            fault_pc_nxt = target;
         end else begin
            pc_nxt    = target;
            fault_nxt = 1'b0;
            state_nxt = credit_state;
         end
`else
         pc_nxt = target & ~XLEN'(3);
`endif
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state    <= S_RESET;
         pc       <= RESET_VECTOR;
         epoch    <= 1'b0;
         credits  <= 4'd0;
`ifdef PCGEN_MISALIGN_CHK_EN
         fault    <= 1'b0;
         fault_pc <= '0;
`endif
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         epoch    <= epoch_nxt;
         credits  <= credits_nxt;
`ifdef PCGEN_MISALIGN_CHK_EN
         fault    <= fault_nxt;
         fault_pc <= fault_pc_nxt;
`endif
      end
   end

   // All outputs come straight from registers
   assign req.o_pc    = pc;
   assign req.o_epoch = epoch;
   assign req.o_valid = (state == S_RUN);
`ifdef PCGEN_MISALIGN_CHK_EN
   assign req.o_fault    = fault;
   assign req.o_fault_pc = fault_pc;
`else
   assign req.o_fault    = 1'b0;
   assign req.o_fault_pc = '0;
`endif
endmodule
